// File: rtl/eth_mac_10g_tx_xgmii.sv
// XGMII transmit framer: turns a 64-bit valid/ready frame stream into START, data,
// terminate, inter-frame-gap idles, and an error word when the source underflows.
module eth_mac_10g_tx_xgmii #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = 8,
   parameter int MIN_IFG    = 12
) (
   input  logic                  tx_clk,
   input  logic                  tx_rst_n,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic [CTRL_WIDTH-1:0] s_tkeep,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   output logic [DATA_WIDTH-1:0] xgmii_txd,
   output logic [CTRL_WIDTH-1:0] xgmii_txc,
   output logic                  stat_tx_frame,
   output logic                  stat_tx_underflow
);

   // Handshake: a beat transfers on a rising tx_clk edge where s_tvalid and s_tready
   // are both 1; s_tready depends only on state, never on s_tvalid.

   localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
   localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
   localparam logic [63:0] ERROR_WORD = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [63:0] TERM0_WORD = 64'h07070707070707FD;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_TERM,
      ST_IFG,
      ST_DRAIN
   } state_t;

   // Idle words needed after a /T/ in lane n so the gap reaches MIN_IFG bytes.
   function automatic logic [2:0] gap_words(input int n);
      int gap;
      gap = MIN_IFG - (8 - n);
      if (gap <= 0) return 3'd0;
      return 3'((gap + 7) / 8);
   endfunction

   localparam logic [2:0] GAP_TERM  = gap_words(0);
   localparam logic [2:0] GAP_DRAIN = gap_words(8);

   state_t      state;
   logic [2:0]  ifg_cnt;
   logic [3:0]  keep_n;
   logic [2:0]  gap_last;
   logic [63:0] term_txd;
   logic [7:0]  term_txc;

   // Count of contiguous ones from bit 0; the lowest zero wins.
   always_comb begin
      keep_n = 4'd8;
      for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
         if (!s_tkeep[i]) keep_n = 4'(i);
      end
   end

   always_comb begin
      term_txd = IDLE_WORD;
      term_txc = 8'hFF << keep_n;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
         if (i < int'(keep_n))
            term_txd[8*i +: 8] = s_tdata[8*i +: 8];
         else if (i == int'(keep_n))
            term_txd[8*i +: 8] = 8'hFD;
      end
      gap_last = gap_words(int'(keep_n));
   end

   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         state             <= ST_IDLE;
         ifg_cnt           <= '0;
         xgmii_txd         <= IDLE_WORD;
         xgmii_txc         <= 8'hFF;
         s_tready          <= 1'b0;
         stat_tx_frame     <= 1'b0;
         stat_tx_underflow <= 1'b0;
      end else begin
         xgmii_txd         <= IDLE_WORD;
         xgmii_txc         <= 8'hFF;
         stat_tx_frame     <= 1'b0;
         stat_tx_underflow <= 1'b0;
         case (state)
            ST_IDLE: begin
               // The first beat stays on the bus; it is consumed in DATA.
               if (s_tvalid && ifg_cnt == '0) begin
                  xgmii_txd <= START_WORD;
                  xgmii_txc <= 8'h01;
                  s_tready  <= 1'b1;
                  state     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (!s_tvalid) begin
                  xgmii_txd         <= ERROR_WORD;
                  stat_tx_underflow <= 1'b1;
                  state             <= ST_DRAIN;
               end else if (!s_tlast) begin
                  xgmii_txd <= s_tdata;
                  xgmii_txc <= 8'h00;
               end else if (keep_n == 4'd8) begin
                  xgmii_txd <= s_tdata;
                  xgmii_txc <= 8'h00;
                  s_tready  <= 1'b0;
                  state     <= ST_TERM;
               end else begin
                  xgmii_txd     <= term_txd;
                  xgmii_txc     <= term_txc;
                  stat_tx_frame <= 1'b1;
                  s_tready      <= 1'b0;
                  ifg_cnt       <= gap_last;
                  state         <= (gap_last == '0) ? ST_IDLE : ST_IFG;
               end
            end
            ST_TERM: begin
               xgmii_txd     <= TERM0_WORD;
               stat_tx_frame <= 1'b1;
               ifg_cnt       <= GAP_TERM;
               state         <= (GAP_TERM == '0) ? ST_IDLE : ST_IFG;
            end
            ST_IFG: begin
               if (ifg_cnt <= 3'd1) begin
                  ifg_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  ifg_cnt <= ifg_cnt - 3'd1;
               end
            end
            ST_DRAIN: begin
               // Abandoned frame: swallow beats up to s_tlast, then a full gap.
               if (s_tvalid && s_tlast) begin
                  s_tready <= 1'b0;
                  ifg_cnt  <= GAP_DRAIN;
                  state    <= (GAP_DRAIN == '0) ? ST_IDLE : ST_IFG;
               end
            end
            default: begin
               s_tready <= 1'b0;
               ifg_cnt  <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_mac_10g_tx_xgmii.sv
// Directed bench for eth_mac_10g_tx_xgmii: frame descriptors drive the stream,
// a negedge monitor compares each XGMII word against an expected queue.
module tb_eth_mac_10g_tx_xgmii;

   localparam int W = 74;  // {stat_frame, stat_underflow, txc[7:0], txd[63:0]}

   logic        tx_clk;
   logic        tx_rst_n;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [63:0] xgmii_txd;
   logic [7:0]  xgmii_txc;
   logic        stat_tx_frame;
   logic        stat_tx_underflow;

   eth_mac_10g_tx_xgmii #(
      .DATA_WIDTH(64),
      .CTRL_WIDTH(8),
      .MIN_IFG   (12)
   ) dut (
      .tx_clk           (tx_clk),
      .tx_rst_n         (tx_rst_n),
      .s_tdata          (s_tdata),
      .s_tkeep          (s_tkeep),
      .s_tvalid         (s_tvalid),
      .s_tready         (s_tready),
      .s_tlast          (s_tlast),
      .xgmii_txd        (xgmii_txd),
      .xgmii_txc        (xgmii_txc),
      .stat_tx_frame    (stat_tx_frame),
      .stat_tx_underflow(stat_tx_underflow)
   );

   // ---------------- clock / reset ----------------
   initial begin
      tx_clk = 1'b0;
      forever #5 tx_clk = ~tx_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_w;
   logic         capture = 1'b0;
   string        cur_case = "none";
   int           word_idx = 0;

   int          fr_beats[$];
   logic [63:0] fr_base[$];
   logic [7:0]  fr_keep[$];
   int          fr_gap[$];

   wire [W-1:0] cur_word = {stat_tx_frame, stat_tx_underflow, xgmii_txc, xgmii_txd};

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [63:0] d, input logic [7:0] c,
                                       input logic fr, input logic un);
      return {fr, un, c, d};
   endfunction

   always @(negedge tx_clk) begin
      if (capture && exp_q.size() > 0) begin
         exp_w = exp_q.pop_front();
         check($sformatf("%s_w%0d", cur_case, word_idx), cur_word, exp_w);
         word_idx++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic last);
      bit done;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = last;
      s_tvalid = 1'b1;
      done     = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge tx_clk);
         if (s_tready) begin
            @(posedge tx_clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) check("handshake_timeout", 1, 0);
   endtask

   task automatic send_frame(input int beats, input logic [63:0] base,
                             input logic [7:0] last_keep, input int gap_at);
      for (int b = 0; b < beats; b++) begin
         send_beat(base ^ 64'(b), (b == beats - 1) ? last_keep : 8'hFF, b == beats - 1);
         if (b == gap_at) begin
            s_tvalid = 1'b0;
            @(posedge tx_clk);
            #1;
         end
      end
   endtask

   task automatic drive_frames();
      while (fr_beats.size() > 0)
         send_frame(fr_beats.pop_front(), fr_base.pop_front(), fr_keep.pop_front(),
                    fr_gap.pop_front());
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic add_frame(input int beats, input logic [63:0] base,
                            input logic [7:0] last_keep, input int gap_at);
      fr_beats.push_back(beats);
      fr_base.push_back(base);
      fr_keep.push_back(last_keep);
      fr_gap.push_back(gap_at);
   endtask

   // Must be entered #1 after a rising edge with the DUT idle.
   task automatic run_case(input string name);
      cur_case = name;
      word_idx = 0;
      fork
         drive_frames();
         begin
            @(negedge tx_clk);
            #1 capture = 1'b1;
         end
      join
      for (int i = 0; i < 64 && exp_q.size() > 0; i++) @(posedge tx_clk);
      if (exp_q.size() != 0) begin
         check({name, "_leftover"}, W'(exp_q.size()), 0);
         exp_q.delete();
      end
      capture = 1'b0;
      repeat (4) @(posedge tx_clk);
      #1;
   endtask

   localparam logic [63:0] IDLE_D = 64'h0707070707070707;
   localparam logic [63:0] START_D = 64'hD5555555555555FB;

   // ---------------- stimulus ----------------
   initial begin
      tx_rst_n = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;

      // Reset holds idle outputs.
      for (int i = 0; i < 3; i++) begin
         @(negedge tx_clk);
         check("rst_word", cur_word, mk(IDLE_D, 8'hFF, 0, 0));
         check("rst_tready", W'(s_tready), 0);
      end
      @(posedge tx_clk);
      #1 tx_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge tx_clk);
         check("idle_word", cur_word, mk(IDLE_D, 8'hFF, 0, 0));
         check("idle_tready", W'(s_tready), 0);
      end
      @(posedge tx_clk);
      #1;

      // 3-beat n=3, 2-beat n=8, 1-beat n=2, all back to back.
      add_frame(3, 64'h8877665544332211, 8'h07, -1);
      add_frame(2, 64'h0123456789ABCDEF, 8'hFF, -1);
      add_frame(1, 64'h1122334455667788, 8'h03, -1);
      exp_q.push_back(mk(START_D, 8'h01, 0, 0));
      exp_q.push_back(mk(64'h8877665544332211, 8'h00, 0, 0));
      exp_q.push_back(mk(64'h8877665544332210, 8'h00, 0, 0));
      exp_q.push_back(mk(64'h07070707FD332213, 8'hF8, 1, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(START_D, 8'h01, 0, 0));
      exp_q.push_back(mk(64'h0123456789ABCDEF, 8'h00, 0, 0));
      exp_q.push_back(mk(64'h0123456789ABCDEE, 8'h00, 0, 0));
      exp_q.push_back(mk(64'h07070707070707FD, 8'hFF, 1, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(START_D, 8'h01, 0, 0));
      exp_q.push_back(mk(64'h0707070707FD7788, 8'hFC, 1, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      run_case("b2b");

      // /T/ in lane 7 needs two idle words; /T/ in lane 1 needs one.
      add_frame(1, 64'hA1A2A3A4A5A6A7A8, 8'h7F, -1);
      add_frame(1, 64'hB1B2B3B4B5B6B7B8, 8'h01, -1);
      exp_q.push_back(mk(START_D, 8'h01, 0, 0));
      exp_q.push_back(mk(64'hFDA2A3A4A5A6A7A8, 8'h80, 1, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(START_D, 8'h01, 0, 0));
      exp_q.push_back(mk(64'h070707070707FDB8, 8'hFE, 1, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      run_case("lane7");

      // Underflow after beat 1, drain to s_tlast, full gap, then a pending frame.
      add_frame(4, 64'hC0C1C2C3C4C5C6C7, 8'hFF, 1);
      add_frame(1, 64'hD1D2D3D4D5D6D7D8, 8'h0F, -1);
      exp_q.push_back(mk(START_D, 8'h01, 0, 0));
      exp_q.push_back(mk(64'hC0C1C2C3C4C5C6C7, 8'h00, 0, 0));
      exp_q.push_back(mk(64'hC0C1C2C3C4C5C6C6, 8'h00, 0, 0));
      exp_q.push_back(mk(64'hFEFEFEFEFEFEFEFE, 8'hFF, 0, 1));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(START_D, 8'h01, 0, 0));
      exp_q.push_back(mk(64'h070707FDD5D6D7D8, 8'hF0, 1, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      run_case("underflow");

      // Asynchronous reset in the middle of a frame.
      s_tdata  = 64'hF0F1F2F3F4F5F6F7;
      s_tkeep  = 8'hFF;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      @(posedge tx_clk);
      #1 check("mid_start", cur_word, mk(START_D, 8'h01, 0, 0));
      @(posedge tx_clk);
      #1 check("mid_d0", cur_word, mk(64'hF0F1F2F3F4F5F6F7, 8'h00, 0, 0));
      check("mid_tready", W'(s_tready), 1);
      #3 tx_rst_n = 1'b0;
      #1 check("async_word", cur_word, mk(IDLE_D, 8'hFF, 0, 0));
      check("async_tready", W'(s_tready), 0);
      s_tvalid = 1'b0;
      @(posedge tx_clk);
      #1 tx_rst_n = 1'b1;
      repeat (2) @(posedge tx_clk);
      #1;

      add_frame(1, 64'hE1E2E3E4E5E6E7E8, 8'hFF, -1);
      exp_q.push_back(mk(START_D, 8'h01, 0, 0));
      exp_q.push_back(mk(64'hE1E2E3E4E5E6E7E8, 8'h00, 0, 0));
      exp_q.push_back(mk(64'h07070707070707FD, 8'hFF, 1, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      exp_q.push_back(mk(IDLE_D, 8'hFF, 0, 0));
      run_case("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
